// File: rtl/proc.sv
// Shared processor constants and types used by the writeback path.
package proc;

    localparam int unsigned ARCH_BITS    = 32;
    localparam int unsigned REG_IDX_BITS = 5;
    localparam int unsigned WB_DEPTH     = 4;

    typedef logic [REG_IDX_BITS-1:0] reg_idx_t;
    typedef logic [ARCH_BITS-1:0]    word_t;

    typedef struct packed {
        reg_idx_t dst;
        word_t    data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/MEM result ports, register-file write port, bypass lookup and occupancy.
interface writeback_arbiter_if #(
    parameter int unsigned DEPTH = proc::WB_DEPTH
);
    import proc::*;

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic      alu_valid;
    logic      alu_ready;
    reg_idx_t  alu_dst;
    word_t     alu_data;
    logic      mem_valid;
    logic      mem_ready;
    reg_idx_t  mem_dst;
    word_t     mem_data;
    logic      wr_en;
    reg_idx_t  wr_dst;
    word_t     wr_data;
    reg_idx_t  src1;
    reg_idx_t  src2;
    logic      byp1_hit;
    logic      byp2_hit;
    word_t     byp1_data;
    word_t     byp2_data;
    logic [CntW-1:0] pending;

    modport master (
        output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data, src1, src2,
        input  alu_ready, mem_ready, wr_en, wr_dst, wr_data,
        input  byp1_hit, byp1_data, byp2_hit, byp2_data, pending
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data, src1, src2,
        output alu_ready, mem_ready, wr_en, wr_dst, wr_data,
        output byp1_hit, byp1_data, byp2_hit, byp2_data, pending
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order pending-write FIFO accepting up to two pushes per cycle, with a
// youngest-match lookup over all queued entries for operand bypass.
module wb_fifo
    import proc::*;
#(
    parameter int unsigned  DEPTH = WB_DEPTH,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push0_i,
    input  wb_entry_t       push0_entry_i,
    input  logic            push1_i,
    input  wb_entry_t       push1_entry_i,
    input  logic            pop_i,
    output logic [CntW-1:0] count_o,
    output wb_entry_t       head_o,
    input  reg_idx_t        src1_i,
    input  reg_idx_t        src2_i,
    output logic            hit1_o,
    output logic            hit2_o,
    output word_t           data1_o,
    output word_t           data2_o
);

    wb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [1:0]      n_push;

    assign n_push  = {1'b0, push0_i} + {1'b0, push1_i};
    assign count_d = count_q + CntW'(n_push) - CntW'(pop_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_q + PtrW'(pop_i);
            wr_q    <= wr_q + PtrW'(n_push);
            count_q <= count_d;
        end
    end

    // push1 only ever accompanies push0, so it lands in the slot after it.
    always_ff @(posedge clk) begin
        if (!rst && push0_i) mem_q[wr_q] <= push0_entry_i;
        if (!rst && push1_i) mem_q[wr_q + PtrW'(1)] <= push1_entry_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;

    // Walk oldest to youngest so the last match seen is the youngest one.
    function automatic logic [ARCH_BITS:0] youngest(input reg_idx_t src);
        logic [ARCH_BITS:0] res;
        res = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [PtrW-1:0] idx;
            idx = rd_q + PtrW'(i);
            if (i < int'(count_q) && mem_q[idx].dst == src) res = {1'b1, mem_q[idx].data};
        end
        return res;
    endfunction

    assign {hit1_o, data1_o} = youngest(src1_i);
    assign {hit2_o, data2_o} = youngest(src2_i);

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and load-unit results into a pending-write queue that drains
// one entry per cycle into the register file, with operand bypass from the queue.
module writeback_arbiter
    import proc::*;
#(
    parameter int unsigned DEPTH    = WB_DEPTH,
    parameter int unsigned NUM_REGS = 32
) (
    input logic               clk,
    input logic               rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned      CntW    = $clog2(DEPTH) + 1;
    localparam logic [CntW:0]    FreeOne = (CntW + 1)'(1);

    logic [CntW-1:0] count;
    logic [CntW:0]   free;
    wb_entry_t       head, alu_entry, mem_entry, push0_entry;
    logic            head_valid, pop, push0, push1;
    logic            alu_ready, mem_ready, alu_fire, mem_fire;
    logic            hit1, hit2;
    word_t           data1, data2;
    logic            rr_q;

    assign head_valid = (count != '0);
    // The head drains this cycle, so its slot is already available to a push.
    assign free = (CntW + 1)'(DEPTH) - {1'b0, count} + {{CntW{1'b0}}, head_valid};

    // At one free slot each ready looks only at the other port's valid.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            if (free > FreeOne) begin
                alu_ready = 1'b1;
                mem_ready = 1'b1;
            end else if (free == FreeOne) begin
                alu_ready = !(bus.mem_valid && rr_q);
                mem_ready = !(bus.alu_valid && !rr_q);
            end
        end
    end

    assign alu_fire    = bus.alu_valid && alu_ready;
    assign mem_fire    = bus.mem_valid && mem_ready;
    assign alu_entry   = '{dst: bus.alu_dst, data: bus.alu_data};
    assign mem_entry   = '{dst: bus.mem_dst, data: bus.mem_data};
    assign push0       = alu_fire || mem_fire;
    assign push0_entry = mem_fire ? mem_entry : alu_entry;
    assign push1       = alu_fire && mem_fire;
    assign pop         = head_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else if (free == FreeOne && bus.alu_valid && bus.mem_valid && push0) begin
            rr_q <= !rr_q;
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (push0),
        .push0_entry_i(push0_entry),
        .push1_i      (push1),
        .push1_entry_i(alu_entry),
        .pop_i        (pop),
        .count_o      (count),
        .head_o       (head),
        .src1_i       (bus.src1),
        .src2_i       (bus.src2),
        .hit1_o       (hit1),
        .hit2_o       (hit2),
        .data1_o      (data1),
        .data2_o      (data2)
    );

    assign bus.alu_ready = alu_ready;
    assign bus.mem_ready = mem_ready;
    assign bus.wr_en     = head_valid && !rst;
    assign bus.wr_dst    = rst ? '0 : head.dst;
    assign bus.wr_data   = rst ? '0 : head.data;
    assign bus.byp1_hit  = hit1 && !rst;
    assign bus.byp2_hit  = hit2 && !rst;
    assign bus.byp1_data = rst ? '0 : data1;
    assign bus.byp2_data = rst ? '0 : data2;
    assign bus.pending   = count;

    assert property (@(posedge clk) disable iff (rst)
        bus.alu_valid |-> (32'(bus.alu_dst) < NUM_REGS));
    assert property (@(posedge clk) disable iff (rst)
        bus.mem_valid |-> (32'(bus.mem_dst) < NUM_REGS));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and resets.
module tb_writeback_arbiter;
    import proc::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.DEPTH(DEPTH)) bus ();

    writeback_arbiter #(
        .DEPTH   (DEPTH),
        .NUM_REGS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    bit   rr;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] s_pending, s_wr_en, s_wr_dst, s_wr_data;
    logic [31:0] s_alu_ready, s_mem_ready, s_byp1_hit, s_byp1_data, s_byp2_hit, s_byp2_data;
    bit          s_ga, s_gm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare DUT outputs with the model, then advance the model.
    task automatic step(input bit r,
                        input bit av, input logic [4:0] ad, input logic [31:0] adat,
                        input bit mv, input logic [4:0] md, input logic [31:0] mdat,
                        input logic [4:0] s1, input logic [4:0] s2);
        int          sz, free;
        bit          ga, gm, h1, h2;
        logic [31:0] d1, d2;
        @(negedge clk);
        rst           = r;
        bus.alu_valid = av;
        bus.alu_dst   = ad;
        bus.alu_data  = adat;
        bus.mem_valid = mv;
        bus.mem_dst   = md;
        bus.mem_data  = mdat;
        bus.src1      = s1;
        bus.src2      = s2;
        #1;
        sz   = q.size();
        free = DEPTH - sz + ((sz > 0) ? 1 : 0);

        s_pending   = 32'(bus.pending);
        s_wr_en     = 32'(bus.wr_en);
        s_wr_dst    = 32'(bus.wr_dst);
        s_wr_data   = bus.wr_data;
        s_alu_ready = 32'(bus.alu_ready);
        s_mem_ready = 32'(bus.mem_ready);
        s_byp1_hit  = 32'(bus.byp1_hit);
        s_byp1_data = bus.byp1_data;
        s_byp2_hit  = 32'(bus.byp2_hit);
        s_byp2_data = bus.byp2_data;

        chk("pending", s_pending, sz);
        if (r) begin
            chk("wr_en_rst", s_wr_en, 0);
        end else if (sz > 0) begin
            chk("wr_en", s_wr_en, 1);
            chk("wr_dst", s_wr_dst, 32'(q[0].dst));
            chk("wr_data", s_wr_data, q[0].data);
        end else begin
            chk("wr_en_idle", s_wr_en, 0);
            chk("wr_dst_idle", s_wr_dst, 0);
            chk("wr_data_idle", s_wr_data, 0);
        end

        h1 = 0; d1 = 0; h2 = 0; d2 = 0;
        if (!r) begin
            foreach (q[i]) begin
                if (q[i].dst == s1) begin h1 = 1; d1 = q[i].data; end
                if (q[i].dst == s2) begin h2 = 1; d2 = q[i].data; end
            end
        end
        chk("byp1_hit", s_byp1_hit, 32'(h1));
        chk("byp1_data", s_byp1_data, d1);
        chk("byp2_hit", s_byp2_hit, 32'(h2));
        chk("byp2_data", s_byp2_data, d2);

        ga = 0; gm = 0;
        if (!r) begin
            if (free >= 2) begin
                ga = av; gm = mv;
            end else if (free == 1) begin
                if (av && mv) begin ga = !rr; gm = rr; end
                else begin ga = av; gm = mv; end
            end
        end
        s_ga = ga;
        s_gm = gm;

        if (r || free == 0) begin
            chk("alu_ready_off", s_alu_ready, 0);
            chk("mem_ready_off", s_mem_ready, 0);
        end else if (free >= 2) begin
            chk("alu_ready_free", s_alu_ready, 1);
            chk("mem_ready_free", s_mem_ready, 1);
        end else if (av && mv) begin
            chk("alu_ready_rr", s_alu_ready, 32'(!rr));
            chk("mem_ready_rr", s_mem_ready, 32'(rr));
        end else if (av) begin
            chk("alu_ready_solo", s_alu_ready, 1);
        end else if (mv) begin
            chk("mem_ready_solo", s_mem_ready, 1);
        end

        if (r) begin
            q.delete();
            rr = 0;
        end else begin
            if (sz > 0) void'(q.pop_front());
            if (gm) q.push_back('{dst: md, data: mdat});
            if (ga) q.push_back('{dst: ad, data: adat});
            if (free == 1 && av && mv) rr = !rr;
        end
    endtask

    task automatic idle(input bit r, input logic [4:0] s1, input logic [4:0] s2);
        step(r, 0, 0, 0, 0, 0, 0, s1, s2);
    endtask

    initial begin
        rr  = 0;
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_dst = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_dst = 0; bus.mem_data = 0;
        bus.src1 = 0; bus.src2 = 0;

        idle(1, 0, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);
        chk("lit_reset_pending", s_pending, 0);

        // Single ALU write through an empty queue.
        step(0, 1, 3, 32'h11, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        chk("lit_036_wr_en", s_wr_en, 1);
        chk("lit_036_wr_dst", s_wr_dst, 3);
        chk("lit_036_wr_data", s_wr_data, 32'h11);
        idle(0, 0, 0);
        chk("lit_036_wr_en_after", s_wr_en, 0);

        // Simultaneous accept: MEM ahead of ALU, bypass returns the younger value.
        step(0, 1, 5, 32'hBB, 1, 5, 32'hAA, 0, 0);
        idle(0, 5, 7);
        chk("lit_037_first_dst", s_wr_dst, 5);
        chk("lit_037_first_data", s_wr_data, 32'hAA);
        chk("lit_037_byp1_hit", s_byp1_hit, 1);
        chk("lit_037_byp1_data", s_byp1_data, 32'hBB);
        chk("lit_041_byp2_hit", s_byp2_hit, 0);
        chk("lit_041_byp2_data", s_byp2_data, 0);
        idle(0, 0, 0);
        chk("lit_037_second_data", s_wr_data, 32'hBB);
        idle(0, 0, 0);
        chk("lit_037_drained", s_wr_en, 0);

        // Both ports held valid: saturate, then alternate ALU/MEM/ALU.
        idle(1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 5'(k), 32'h100 + 32'(k), 1, 5'(k + 8), 32'h200 + 32'(k), 0, 0);
            if (k >= 3) begin
                chk("lit_038_pending", s_pending, 4);
                chk("lit_038_alu_ready", s_alu_ready, (k == 4) ? 0 : 1);
                chk("lit_038_mem_ready", s_mem_ready, (k == 4) ? 1 : 0);
                chk("lit_038_model_grant", 32'(s_ga), (k == 4) ? 0 : 1);
            end
        end

        // Full queue, single valid port still gets the popped slot.
        step(0, 0, 0, 0, 1, 9, 32'h300, 0, 0);
        chk("lit_039_mem_ready", s_mem_ready, 1);
        idle(0, 0, 0);
        chk("lit_039_pending", s_pending, 4);

        // Reset mid-operation at pending=3; rr returns to ALU priority.
        step(1, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("lit_040_pending_before", s_pending, 3);
        idle(0, 9, 0);
        chk("lit_040_pending_after", s_pending, 0);
        chk("lit_040_wr_en_after", s_wr_en, 0);
        chk("lit_040_no_stale_byp", s_byp1_hit, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 1, 32'h400 + 32'(k), 1, 2, 32'h500 + 32'(k), 0, 0);
        chk("lit_040_rr_alu", s_alu_ready, 1);
        chk("lit_040_rr_mem", s_mem_ready, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write queue entries; SHALL be a power of two, 2..8.
REQ-002 Parameter NUM_REGS, default 32, architectural register count; register index width is 5.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alu_valid  input  1  ALU result offered this cycle.
REQ-006 alu_ready  output  1  ALU result accepted when alu_valid and alu_ready are both high.
REQ-007 alu_dst  input  5  ALU destination register.
REQ-008 alu_data  input  proc.ARCH_BITS  ALU result value.
REQ-009 mem_valid, mem_ready, mem_dst, mem_data  in/out/in/in  1/1/5/proc.ARCH_BITS  same as REQ-005..008, for the load unit.
REQ-010 wr_en  output  1  drives register-file writeEnable.
REQ-011 wr_dst  output  5  drives register-file dst.
REQ-012 wr_data  output  proc.ARCH_BITS  drives register-file wData.
REQ-013 src1, src2  input  5 each  bypass lookup indices, same as register-file read indices.
REQ-014 byp1_hit, byp2_hit  output  1 each  lookup index matches a queued entry.
REQ-015 byp1_data, byp2_data  output  proc.ARCH_BITS each  value of youngest matching entry; 0 when no hit.
REQ-016 pending  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-017 Queued writes SHALL be held in a DEPTH-entry in-order FIFO of {dst, data}, registered storage.
REQ-018 When pending>0, the head SHALL be presented combinationally on wr_en=1, wr_dst, wr_data, and popped at that posedge; the register file always accepts.
REQ-019 When pending=0, wr_en=0; wr_dst and wr_data SHALL be 0.
REQ-020 Effective free slots SHALL be DEPTH-pending+(pending>0 ? 1:0), accounting for the same-cycle pop.
REQ-021 Free>=2: alu_ready=mem_ready=1; if both accepted, the MEM entry SHALL be enqueued ahead of the ALU entry.
REQ-022 Free=1: only one ready is high; if exactly one port is valid, that port is granted; if both are valid, the port selected by round-robin flag rr is granted (rr=0 ALU, rr=1 MEM).
REQ-023 rr SHALL toggle only on a cycle where free=1, both ports were valid and a grant occurred.
REQ-024 Free=0: both readies low.
REQ-025 ready SHALL NOT depend on the same port's valid; it MAY depend on the other port's valid (REQ-022).
REQ-026 Latency: a result accepted at posedge N SHALL appear on wr_* in cycle N+1 at earliest; FIFO order is write order.
REQ-027 Writes to register 0 SHALL be queued and written like any other index.
REQ-028 Bypass: byp_hit SHALL reflect all queued entries, including the head being written this cycle, and exclude same-cycle incoming requests; on multiple matches, the youngest entry SHALL win.
REQ-029 Pointer wrap SHALL be modulo DEPTH; full versus empty is distinguished by pending.
REQ-030 Simultaneous push and pop at pending=DEPTH SHALL be legal (one push); pending is updated by pushes minus pop.

Reset
REQ-031 While rst=1 at a posedge: pending=0, pointers=0, rr=0, and all queued entries are discarded, including mid-operation.
REQ-032 While rst is high: wr_en=0, alu_ready=0, mem_ready=0, byp*_hit=0.
REQ-033 Storage contents need not be reset; outputs SHALL NOT expose them while pending=0.

Structure
REQ-034 proc.ARCH_BITS, REG_IDX_BITS=5 and WB_DEPTH=4 SHALL be defined in the shared proc package.
REQ-035 The FIFO with youngest-match lookup SHALL be a sub-module wb_fifo; arbitration and the rr flag remain in writeback_arbiter.

Verification
REQ-036 Empty queue, alu_valid dst=3 data=0x11 -> next cycle wr_en=1, wr_dst=3, wr_data=0x11; the following cycle wr_en=0.
REQ-037 Both ports valid, same cycle, pending=0 (mem dst=5 0xAA, alu dst=5 0xBB) -> writes in order 5/0xAA then 5/0xBB; src1=5 between them -> byp1_hit=1, byp1_data=0xBB.
REQ-038 Hold both ports valid continuously with DEPTH=4 -> pending saturates at 4, readies never both high at free=1, and grants alternate ALU, MEM, ALU while free=1.
REQ-039 pending=4 and a single valid port -> that port is accepted (free=1 via pop), and pending stays 4.
REQ-040 Assert rst with pending=3 -> next cycle pending=0, wr_en=0, no further writes of the old entries, rr=0.
REQ-041 src2=7 with no queued entry for 7 -> byp2_hit=0, byp2_data=0.
